// File: rtl/stream_insert_header.sv
// stream_insert_header
//   Prepends a per-packet header of 0..DATA_BYTE_WD-1 bytes to a byte stream
//   carried as data/keep/last beats with valid/ready handshakes. Every payload
//   beat is realigned behind the header bytes. If the shifted last beat does
//   not fit, one extra tail beat is emitted. The output is fully registered.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   valid_in/data_in/keep_in/last_in    payload beat in (byte lane MSB first)
//   ready_in                            payload accept
//   valid_insert/data_insert            header (valid bytes in low N lanes)
//   byte_insert_cnt                     header byte count N (0 = pass-through)
//   ready_insert                        header accept
//   valid_out/data_out/keep_out/last_out  output beat (keep high-aligned)
//   ready_out                           downstream ready
module stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  typedef enum logic [1:0] {IDLE, PASS, TAIL} state_e;

  state_e                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  n_q, n_d;
  // Residual holds the whole previous word; only its low N bytes are ever used.
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [DATA_BYTE_WD-1:0] tkeep_q, tkeep_d;
  logic                    valid_q, valid_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    last_q, last_d;

  logic                    out_free, in_fire, hdr_fire;
  logic [BYTE_CNT_WD+2:0]  sh;
  logic [DATA_WD-1:0]      cat_data, tail_data;
  logic [DATA_BYTE_WD-1:0] cat_keep, spill_keep;

  assign out_free     = !valid_q || ready_out;
  assign ready_insert = (state_q == IDLE);
  assign ready_in     = (state_q == PASS) && out_free;
  assign in_fire      = valid_in && ready_in;
  assign hdr_fire     = valid_insert && ready_insert;

  // Byte shift by N: the residual bytes slide in on top, the word moves down.
  assign sh        = {n_q, 3'b000};
  assign cat_data  = DATA_WD'({res_q, data_in} >> sh);
  assign cat_keep  = DATA_BYTE_WD'({{DATA_BYTE_WD{1'b1}}, keep_in} >> n_q);
  assign tail_data = DATA_WD'({res_q, {DATA_WD{1'b0}}} >> sh);
  // Keep bits pushed out of the bottom of the beat; nonzero means a tail beat
  // is needed, and the value itself is the tail keep (high-aligned).
  assign spill_keep = DATA_BYTE_WD'({keep_in, {DATA_BYTE_WD{1'b0}}} >> n_q);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    res_d   = res_q;
    tkeep_d = tkeep_q;
    valid_d = valid_q && !ready_out;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (hdr_fire) begin
          n_d     = byte_insert_cnt;
          res_d   = data_insert;
          state_d = PASS;
        end
      end
      PASS: begin
        if (in_fire) begin
          valid_d = 1'b1;
          data_d  = cat_data;
          keep_d  = cat_keep;
          last_d  = 1'b0;
          res_d   = data_in;
          if (last_in) begin
            if (|spill_keep) begin
              tkeep_d = spill_keep;
              state_d = TAIL;
            end else begin
              last_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      TAIL: begin
        if (out_free) begin
          valid_d = 1'b1;
          data_d  = tail_data;
          keep_d  = tkeep_q;
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      res_q   <= '0;
      tkeep_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      res_q   <= res_d;
      tkeep_q <= tkeep_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_stream_insert_header.sv
// Bench for stream_insert_header: a byte-stream scoreboard (header bytes then
// payload bytes, re-chunked into high-aligned beats) checked on every output
// handshake, plus literal expectations for the directed packets.
module tb_stream_insert_header;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, last_in, ready_in;
  logic [31:0]   data_in;
  logic [W-1:0]  keep_in;
  logic          valid_insert, ready_insert;
  logic [31:0]   data_insert;
  logic [1:0]    byte_insert_cnt;
  logic          valid_out, last_out, ready_out;
  logic [31:0]   data_out;
  logic [W-1:0]  keep_out;

  stream_insert_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
    .last_in(last_in), .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  d;
    logic [W-1:0] k;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  beat_t got[$];
  int    n_pass = 0, n_total = 0;
  int    rdy_pct = 100;

  logic [31:0]  pd[8];
  int           nb;
  logic [W-1:0] lk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: flatten to bytes, then re-chunk into W-byte beats.
  task automatic model_pkt(input int n, input logic [31:0] h);
    logic [7:0] q[$];
    beat_t e;
    int cnt, k;
    for (int i = n - 1; i >= 0; i--) q.push_back(h[8*i +: 8]);
    for (int b = 0; b < nb; b++) begin
      cnt = (b == nb - 1) ? $countones(lk) : W;
      for (int j = 0; j < cnt; j++) q.push_back(pd[b][8*(W-1-j) +: 8]);
    end
    while (q.size() != 0) begin
      e.d = '0; e.k = '0;
      k = (q.size() < W) ? q.size() : W;
      for (int j = 0; j < k; j++) begin
        e.d[8*(W-1-j) +: 8] = q.pop_front();
        e.k[W-1-j] = 1'b1;
      end
      e.l = (q.size() == 0);
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1 ready_out = ($urandom_range(99) < rdy_pct);
  end

  // Compare process: every accepted output beat against the scoreboard.
  always @(negedge clk) begin
    beat_t e, g;
    logic [31:0] m;
    if (rst_n) begin
      if ($isunknown({valid_out, ready_in, ready_insert})) chk("ctrl_x", 1, 0);
      if (valid_out && ready_out) begin
        chk("out_x", {63'd0, $isunknown({data_out, keep_out, last_out})}, 0);
        g.d = data_out; g.k = keep_out; g.l = last_out;
        got.push_back(g);
        chk("exp_nonempty", {63'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          m = '0;
          for (int i = 0; i < W; i++) if (e.k[i]) m[8*i +: 8] = 8'hFF;
          chk("keep", {60'd0, keep_out}, {60'd0, e.k});
          chk("last", {63'd0, last_out}, {63'd0, e.l});
          chk("data", {32'd0, data_out & m}, {32'd0, e.d & m});
        end
      end
    end
  end

  task automatic send_hdr(input int n, input logic [31:0] h);
    int t = 0;
    logic f = 1'b0;
    repeat ($urandom_range(2)) @(posedge clk);
    #1;
    valid_insert = 1'b1; data_insert = h; byte_insert_cnt = 2'(n);
    while (!f) begin
      @(negedge clk);
      f = ready_insert;
      if (t == 0) chk("no_payload_in_idle", {63'd0, ready_in}, 0);
      @(posedge clk); #1;
      t++;
      if (!f && t > 1000) begin chk("hdr_timeout", 0, 1); break; end
    end
    valid_insert = 1'b0; data_insert = $urandom;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [W-1:0] k, input logic l);
    int t = 0;
    logic f = 1'b0;
    if ($urandom_range(1) == 1) begin @(posedge clk); #1; end
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    while (!f) begin
      @(negedge clk);
      f = ready_in;
      chk("no_hdr_in_pass", {63'd0, ready_insert}, 0);
      @(posedge clk); #1;
      t++;
      if (!f && t > 1000) begin chk("beat_timeout", 0, 1); break; end
    end
    valid_in = 1'b0; data_in = $urandom; last_in = 1'b0;
  endtask

  task automatic run_pkt(input int n, input logic [31:0] h);
    model_pkt(n, h);
    send_hdr(n, h);
    for (int b = 0; b < nb; b++)
      send_beat(pd[b], (b == nb - 1) ? lk : {W{1'b1}}, b == nb - 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); t++; end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_pkt(input int n);
    int v;
    nb = $urandom_range(1, 4);
    for (int b = 0; b < nb; b++) pd[b] = $urandom;
    v = $urandom_range(1, W);
    lk = 4'hF << (W - v);
    run_pkt(n, $urandom);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 0; data_in = 0; keep_in = 0; last_in = 0;
    valid_insert = 0; data_insert = 0; byte_insert_cnt = 0; ready_out = 1;
    #1;
    chk("rst_valid_out", {63'd0, valid_out}, 0);
    chk("rst_data_keep_last", {27'd0, data_out, keep_out, last_out}, 0);
    chk("rst_ready_insert", {63'd0, ready_insert}, 1);
    chk("rst_ready_in", {63'd0, ready_in}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // N=2, tail path
    rdy_pct = 100;
    got.delete();
    pd[0] = 32'h11223344; pd[1] = 32'h55667788; pd[2] = 32'h99AABBCC; pd[3] = 32'hDDEEFF00;
    nb = 4; lk = 4'b1111;
    run_pkt(2, 32'h0000BEEF);
    chk("tail_busy_after_last", {63'd0, ready_insert}, 0);
    drain();
    chk("n2_cnt", got.size(), 5);
    if (got.size() == 5) begin
      chk("n2_b0", {32'd0, got[0].d}, 64'hBEEF1122);
      chk("n2_b1", {32'd0, got[1].d}, 64'h33445566);
      chk("n2_b2", {32'd0, got[2].d}, 64'h778899AA);
      chk("n2_b3", {27'd0, got[3].d, got[3].k, got[3].l}, {27'd0, 32'hBBCCDDEE, 4'b1111, 1'b0});
      chk("n2_tail", {43'd0, got[4].d[31:16], got[4].k, got[4].l}, {43'd0, 16'hFF00, 4'b1100, 1'b1});
    end

    // N=1, no tail
    got.delete();
    lk = 4'b1000;
    run_pkt(1, 32'h000000A5);
    drain();
    chk("n1_cnt", got.size(), 4);
    if (got.size() == 4) begin
      chk("n1_b0", {32'd0, got[0].d}, 64'hA5112233);
      chk("n1_last", {43'd0, got[3].d[31:16], got[3].k, got[3].l}, {43'd0, 16'hCCDD, 4'b1100, 1'b1});
    end

    // N=3, exactly fills the last beat
    got.delete();
    nb = 2; lk = 4'b1000;
    run_pkt(3, 32'h00ABCDEF);
    chk("n3_ready_insert_next", {63'd0, ready_insert}, 1);
    drain();
    chk("n3_cnt", got.size(), 2);
    if (got.size() == 2) begin
      chk("n3_b0", {32'd0, got[0].d}, 64'hABCDEF11);
      chk("n3_b1", {27'd0, got[1].d, got[1].k, got[1].l}, {27'd0, 32'h22334455, 4'b1111, 1'b1});
    end

    // N=0 pass-through
    for (int p = 0; p < 8; p++) begin
      nb = 4;
      for (int b = 0; b < nb; b++) pd[b] = $urandom;
      lk = 4'hF << $urandom_range(0, 3);
      run_pkt(0, $urandom);
    end
    drain();

    // Random traffic with backpressure
    rdy_pct = 50;
    for (int p = 0; p < 200; p++) rand_pkt($urandom_range(0, 3));
    drain();

    // Reset mid-packet while output is stalled
    rdy_pct = 0; ready_out = 1'b0;
    send_hdr(2, 32'h00001234);
    send_beat(32'hCAFEF00D, 4'hF, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", {63'd0, valid_out}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_out", {63'd0, valid_out}, 0);
    chk("mid_rst_ready_in", {63'd0, ready_in}, 0);
    chk("mid_rst_ready_insert", {63'd0, ready_insert}, 1);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rdy_pct = 50;
    got.delete();
    pd[0] = 32'h01020304; pd[1] = 32'h05060708; nb = 2; lk = 4'b1110;
    run_pkt(3, 32'h00AABBCC);
    drain();
    chk("post_rst_cnt", got.size(), 3);
    if (got.size() == 3)
      chk("post_rst_b0", {32'd0, got[0].d}, 64'hAABBCC01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running want finished");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stream_insert_header.md
Name: stream_insert_header

Overview:
- Transmit-side counterpart of stream_remove: prepends a per-packet header of 0..DATA_BYTE_WD-1 bytes to an AXI-Stream-style packet (data/keep/last, valid/ready).
- Realigns every following beat and emits an extra tail beat when the shifted payload overflows.
- Sits between a packet source and the downstream stream sink; output is fully registered.

Parameters:
DATA_WD, 32, data bus width in bits (multiple of 8).
DATA_BYTE_WD, DATA_WD/8, bytes per beat.
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of header byte count.

Ports:
clk  input  1  clock, all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
valid_in  input  1  payload beat valid.
data_in  input  DATA_WD  payload; byte lane DATA_BYTE_WD-1 (MSB) is the first byte in stream order.
keep_in  input  DATA_BYTE_WD  byte enables; all ones except on last beat.
last_in  input  1  final payload beat.
ready_in  output  1  payload beat accepted when valid_in && ready_in.
valid_insert  input  1  header valid.
data_insert  input  DATA_WD  header; valid bytes are the low byte_insert_cnt lanes, MSB-first order.
byte_insert_cnt  input  BYTE_CNT_WD  header byte count N; 0 = pass-through.
ready_insert  output  1  header accepted when valid_insert && ready_insert.
valid_out  output  1  output beat valid.
data_out  output  DATA_WD  output data.
keep_out  output  DATA_BYTE_WD  output byte enables, high-aligned.
last_out  output  1  final output beat.
ready_out  input  1  downstream ready.

Behaviour:
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, state=IDLE, N register=0, residual=0.
- ready_insert = (state==IDLE). ready_in = (state==PASS) && (!valid_out || ready_out). Both are combinational from state and output register.
- Output register: loads whenever a new beat is produced. Otherwise valid_out clears on ready_out, and data, keep and last hold while valid_out && !ready_out.
- IDLE: on header fire, latch N and the residual (header low N bytes, keep = N ones), then go to PASS. No output activity.
- PASS, on input fire:
  - concat = {residual low N bytes, data_in}, taken as the top W+N bytes.
  - data_out = top W bytes of concat.
  - keep_out = top W bits of {N ones, keep_in}.
  - New residual = data_in low N bytes, with residual keep = keep_in low N bits.
- Last beat: let V = popcount(keep_in).
  - If V+N <= W: last_out=1, keep_out has the top V+N bits set, go to IDLE.
  - Else: last_out=0, keep_out all ones, go to TAIL.
- TAIL: ready_in=0. When the output register is free, emit {residual bytes in top N lanes, zeros}, keep = top (V+N-W) bits set, last_out=1, go to IDLE.
- Throughput: one beat per cycle in PASS with ready_out high.
- Latency: input fire to valid_out is 1 cycle.
- Each packet boundary costs one input-idle cycle (header accept in IDLE), plus one for TAIL if taken.
- N=0: output equals input beat-for-beat, one cycle late; TAIL is never entered.
- A header is never accepted in the same cycle as a payload beat. Payload is never accepted before its header.
- Backpressure: no data lost or duplicated. ready_in deasserts while valid_out && !ready_out.
- Reset mid-packet: all state and the output register clear immediately (async). The partial packet is discarded and the next header starts a fresh packet.
- Illegal input has undefined output and must not deadlock after reset:
  - keep_in not all ones on a non-last beat;
  - non-contiguous last-beat keep;
  - keep_in=0.

Test Plan:
- N=2, data_insert=0x0000BEEF; payload 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 (last keep 1111) -> out 0xBEEF1122, 0x33445566, 0x778899AA, 0xBBCCDDEE (keep 1111), then 0xFF00xxxx keep 1100 last (TAIL path).
- N=1, data_insert=0x000000A5; 4 beats, last keep 1000 -> 4 output beats: first 0xA5 followed by payload bytes; final beat keep 1100 last=1; no TAIL.
- N=3, last keep 1000 -> V+N=4: final beat keep 1111 last=1; no TAIL; ready_insert high on the next cycle.
- N=0, random 4-beat packets -> data/keep/last identical to input, one cycle delayed.
- ready_out random 50%, 200 packets with random N (0..3), random last keep and random valid_in/valid_insert -> output byte stream matches the scoreboard (header bytes then payload bytes) with correct last/keep; no X on outputs.
- rst_n pulsed low mid-packet while valid_out=1 -> valid_out=0, ready_in=0, ready_insert=1 immediately; the following packet is output correctly.
